// File: rtl/regfile_arbiter.sv
// Two-port (A/B) valid/ready front end to one 2**AW x DW register file, with a clear sweep after reset/clr_start.
// Latency: writes commit at the accepting edge; read data/rvalid one cycle after acceptance.
// Backpressure: one grant per cycle, round-robin (fixed A-priority if REGFILE_ARB_FIXED_PRIO_EN); none during clear.
module regfile_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [DW-1:0] mem_q [2**AW];
  logic          a_rvalid_q, b_rvalid_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic          a_gnt, b_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

`ifndef REGFILE_ARB_FIXED_PRIO_EN
  logic last_b_q;
`endif

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (state_q == ST_RUN) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      a_gnt = a_valid;
      b_gnt = b_valid & ~a_valid;
`else
      // On contention the requester not served last wins.
      if (a_valid && b_valid) begin
        a_gnt = last_b_q;
        b_gnt = ~last_b_q;
      end else begin
        a_gnt = a_valid;
        b_gnt = b_valid;
      end
`endif
    end
  end

  assign a_ready  = a_gnt;
  assign b_ready  = b_gnt;
  assign clr_busy = (state_q == ST_CLEAR);
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clr_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
    end else if (a_gnt && a_we) begin
      mem_we    = 1'b1;
      mem_waddr = a_addr;
      mem_wdata = a_wdata;
    end else if (b_gnt && b_we) begin
      mem_we    = 1'b1;
      mem_waddr = b_addr;
      mem_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      a_rvalid_q <= a_gnt & ~a_we;
      b_rvalid_q <= b_gnt & ~b_we;
      if (a_gnt && !a_we) a_rdata_q <= mem_q[a_addr];
      if (b_gnt && !b_we) b_rdata_q <= mem_q[b_addr];
    end
  end

`ifndef REGFILE_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b_q <= 1'b1;
    end else if (a_gnt) begin
      last_b_q <= 1'b0;
    end else if (b_gnt) begin
      last_b_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter (default round-robin build): directed steps then constrained-random traffic
// checked every cycle against a register-file model.
module tb_regfile_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, clr_start, clr_busy;
  logic          a_valid, a_ready, a_we, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_ready, b_we, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;

  regfile_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Model state: remaining clear cycles, storage contents, last winner, response regs.
  int            m_cnt;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_last_b;
  bit            m_rva, m_rvb;
  logic [DW-1:0] m_rda, m_rdb;
  bit            a_pend, b_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = DEPTH;
    foreach (m_mem[i]) m_mem[i] = '0;
    m_last_b = 1'b1;
    m_rva = 0; m_rvb = 0;
    m_rda = '0; m_rdb = '0;
    a_pend = 0; b_pend = 0;
  endtask

  task automatic set_a(input bit v, input bit we, input int addr, input int data);
    a_valid = v; a_we = we; a_addr = AW'(addr); a_wdata = DW'(data);
  endtask

  task automatic set_b(input bit v, input bit we, input int addr, input int data);
    b_valid = v; b_we = we; b_addr = AW'(addr); b_wdata = DW'(data);
  endtask

  task automatic idle();
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    clr_start = 1'b0;
  endtask

  // Called just after a negedge with inputs already applied; returns just after the next negedge.
  task automatic cycle();
    bit ga, gb;
    #1;
    ga = 0; gb = 0;
    if (m_cnt == 0) begin
      if (a_valid && b_valid) begin
        ga = m_last_b;
        gb = !m_last_b;
      end else begin
        ga = a_valid;
        gb = b_valid;
      end
    end
    chk("a_ready", {31'd0, a_ready}, {31'd0, ga});
    chk("b_ready", {31'd0, b_ready}, {31'd0, gb});
    @(posedge clk);
    m_rva = 0; m_rvb = 0;
    if (m_cnt > 0) begin
      m_cnt--;
    end else begin
      if (ga) begin
        if (a_we) m_mem[a_addr] = a_wdata;
        else begin m_rva = 1; m_rda = m_mem[a_addr]; end
        m_last_b = 0;
      end
      if (gb) begin
        if (b_we) m_mem[b_addr] = b_wdata;
        else begin m_rvb = 1; m_rdb = m_mem[b_addr]; end
        m_last_b = 1;
      end
      if (clr_start) begin
        m_cnt = DEPTH;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end
    a_pend = a_valid && !ga;
    b_pend = b_valid && !gb;
    #1;
    chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, m_rva});
    chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, m_rvb});
    chk("a_rdata", {24'd0, a_rdata}, {24'd0, m_rda});
    chk("b_rdata", {24'd0, b_rdata}, {24'd0, m_rdb});
    chk("clr_busy", {31'd0, clr_busy}, {31'd0, (m_cnt > 0)});
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("rst_a_rdata", {24'd0, a_rdata}, 32'd0);
    chk("rst_b_rdata", {24'd0, b_rdata}, 32'd0);
    chk("rst_clr_busy", {31'd0, clr_busy}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Power-up sweep, then reads of cleared entries.
    for (int i = 0; i < DEPTH; i++) cycle();
    chk("sweep_done", {31'd0, clr_busy}, 32'd0);
    set_a(1, 0, 9, 0);  cycle();
    set_a(1, 0, 15, 0); cycle();
    idle(); cycle();

    // A writes 0x5A to entry 3, B reads it on the next cycle.
    set_a(1, 1, 3, 'h5A); cycle();
    idle(); set_b(1, 0, 3, 0); cycle();
    idle(); cycle();
    chk("raw_b_rdata", {24'd0, b_rdata}, 32'h5A);

    // Sustained contention alternates A,B,A,B,A,B.
    set_a(1, 0, 1, 0); set_b(1, 0, 2, 0);
    for (int i = 0; i < 6; i++) cycle();
    idle(); cycle();

    // B wins while A holds a read; A accepted next, single response pulse.
    set_a(1, 0, 7, 0); cycle();
    set_a(1, 0, 3, 0); set_b(1, 1, 9, 'h33); cycle();
    set_b(0, 0, 0, 0); cycle();
    idle(); cycle(); cycle();

    // Fill with 0xFF, then clr_start alongside an accepted read.
    for (int i = 0; i < DEPTH; i++) begin set_a(1, 1, i, 'hFF); cycle(); end
    set_a(1, 0, 5, 0); clr_start = 1'b1; cycle();
    chk("clr_cycle_read", {24'd0, a_rdata}, 32'hFF);
    clr_start = 1'b0; set_b(1, 0, 6, 0);
    for (int i = 0; i < DEPTH; i++) cycle();
    cycle(); cycle();
    set_b(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin set_a(1, 0, i * 4 + 1, 0); cycle(); end
    idle(); cycle();

    // Reset drops an in-flight read response.
    set_a(1, 0, 2, 0); cycle();
    idle();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Reset at sweep cycle 7 restarts a full 16-cycle sweep.
    for (int i = 0; i < 7; i++) cycle();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) cycle();

    // Random traffic honouring hold-until-accepted.
    for (int n = 0; n < 400; n++) begin
      if (!a_pend) set_a($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                         $urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
      if (!b_pend) set_b($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                         $urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
      clr_start = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle();
    for (int i = 0; i < DEPTH + 2; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
